// File: rtl/puf_chall_sequencer.sv
// rtl/puf_chall_sequencer.sv - sweeps a challenge range through a PUF core and streams tagged responses
// Each challenge gets its own core reset, settle window and bounded wait for ready.
module puf_chall_sequencer #(
  parameter int CHALL_W    = 8,
  parameter int RESP_W     = 8,
  parameter int RST_PULSE  = 1,
  parameter int SETTLE_CYC = 2,
  parameter int TIMEOUT    = 255
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic [CHALL_W-1:0] chall_first_i,
  input  logic [CHALL_W-1:0] chall_last_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               timeout_err_o,
  output logic               puf_en_o,
  output logic               puf_rst_n_o,
  output logic [CHALL_W-1:0] puf_chall_o,
  input  logic               puf_ready_i,
  input  logic [RESP_W-1:0]  puf_resp_i,
  output logic               resp_valid_o,
  input  logic               resp_ready_i,
  output logic [CHALL_W-1:0] resp_chall_o,
  output logic [RESP_W-1:0]  resp_data_o,
  output logic               resp_err_o
);

  localparam int MAX_A = (RST_PULSE > SETTLE_CYC) ? RST_PULSE : SETTLE_CYC;
  localparam int MAX_C = (MAX_A > TIMEOUT) ? MAX_A : TIMEOUT;
  localparam int CNT_W = $clog2(MAX_C + 1);

  localparam logic [CNT_W-1:0] RST_END    = CNT_W'(RST_PULSE - 1);
  localparam logic [CNT_W-1:0] SETTLE_END = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] WAIT_END   = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_PRST, S_SETTLE, S_WAIT, S_OUT, S_NEXT, S_FIN
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CHALL_W-1:0]  cur_q, cur_d;
  logic [CHALL_W-1:0]  last_q, last_d;
  logic [CHALL_W-1:0]  resp_chall_q, resp_chall_d;
  logic [RESP_W-1:0]   resp_data_q, resp_data_d;
  logic                resp_err_q, resp_err_d;
  logic                terr_q, terr_d;
  logic                busy;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      cur_q        <= '0;
      last_q       <= '0;
      resp_chall_q <= '0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
      terr_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cur_q        <= cur_d;
      last_q       <= last_d;
      resp_chall_q <= resp_chall_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
      terr_q       <= terr_d;
    end
  end

  // FIN already reports not-busy, so a start landing there begins the next sweep at once.
  assign busy = (state_q != S_IDLE) && (state_q != S_FIN);

  always_comb begin
    state_d      = state_q;
    cnt_d        = '0;
    cur_d        = cur_q;
    last_d       = last_q;
    resp_chall_d = resp_chall_q;
    resp_data_d  = resp_data_q;
    resp_err_d   = resp_err_q;
    terr_d       = terr_q;

    case (state_q)
      S_IDLE, S_FIN: begin
        if (start_i) begin
          cur_d   = chall_first_i;
          last_d  = chall_last_i;
          terr_d  = 1'b0;
          state_d = S_PRST;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PRST: begin
        if (cnt_q == RST_END) state_d = S_SETTLE;
        else                  cnt_d   = cnt_q + CNT_W'(1);
      end
      S_SETTLE: begin
        if (cnt_q == SETTLE_END) state_d = S_WAIT;
        else                     cnt_d   = cnt_q + CNT_W'(1);
      end
      S_WAIT: begin
        if (puf_ready_i) begin
          resp_data_d  = puf_resp_i;
          resp_chall_d = cur_q;
          resp_err_d   = 1'b0;
          state_d      = S_OUT;
        end else if (cnt_q == WAIT_END) begin
          resp_data_d  = '0;
          resp_chall_d = cur_q;
          resp_err_d   = 1'b1;
          terr_d       = 1'b1;
          state_d      = S_OUT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_OUT: begin
        if (resp_ready_i) state_d = S_NEXT;
      end
      S_NEXT: begin
        if (cur_q == last_q) begin
          state_d = S_FIN;
        end else begin
          cur_d   = cur_q + CHALL_W'(1);
          state_d = S_PRST;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort overrides everything, including a handshake in OUT; the sticky error survives.
    if (abort_i && busy) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end
  end

  assign busy_o        = busy;
  assign done_o        = (state_q == S_FIN);
  assign timeout_err_o = terr_q;
  assign puf_en_o      = busy;
  assign puf_rst_n_o   = (state_q != S_PRST);
  assign puf_chall_o   = cur_q;
  assign resp_valid_o  = (state_q == S_OUT);
  assign resp_chall_o  = resp_chall_q;
  assign resp_data_o   = resp_data_q;
  assign resp_err_o    = resp_err_q;

endmodule

// File: tb/tb_puf_chall_sequencer.sv
// tb/tb_puf_chall_sequencer.sv - directed bench for puf_chall_sequencer with a small PUF core model
module tb_puf_chall_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] first = 8'h00;
  logic [7:0] last = 8'h00;
  logic       resp_ready = 1'b0;
  logic       busy, done, terr, puf_en, puf_rst_n, resp_valid, resp_err;
  logic [7:0] puf_chall, resp_chall, resp_data, puf_resp;
  logic       puf_ready;

  logic [1:0] mcnt = 2'd0;
  logic       blk_en = 1'b0;
  logic [7:0] blk_chall = 8'h00;

  int nchk = 0;
  int nerr = 0;
  logic [31:0] rq[$];
  int          tq[$];
  logic [7:0]  pq[$];
  int          done_cnt = 0;
  int          cyc = 0;
  logic        prev_rst_n = 1'b1;

  puf_chall_sequencer #(
    .CHALL_W(8), .RESP_W(8), .RST_PULSE(1), .SETTLE_CYC(2), .TIMEOUT(16)
  ) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort),
    .chall_first_i(first), .chall_last_i(last),
    .busy_o(busy), .done_o(done), .timeout_err_o(terr),
    .puf_en_o(puf_en), .puf_rst_n_o(puf_rst_n), .puf_chall_o(puf_chall),
    .puf_ready_i(puf_ready), .puf_resp_i(puf_resp),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
    .resp_chall_o(resp_chall), .resp_data_o(resp_data), .resp_err_o(resp_err)
  );

  always #5 clk = ~clk;

  // Core model: ready three cycles after reset release, response = challenge ^ A5.
  always @(posedge clk) mcnt <= !puf_rst_n ? 2'd0 : ((mcnt == 2'd3) ? 2'd3 : mcnt + 2'd1);
  assign puf_ready = puf_rst_n && (mcnt == 2'd3) && !(blk_en && (puf_chall == blk_chall));
  assign puf_resp  = puf_chall ^ 8'hA5;

  initial forever begin
    @(negedge clk);
    cyc++;
    if (resp_valid && resp_ready) begin
      rq.push_back({15'd0, resp_err, resp_chall, resp_data});
      tq.push_back(cyc);
    end
    if (done) done_cnt++;
    if (!puf_rst_n && prev_rst_n) pq.push_back(puf_chall);
    prev_rst_n = puf_rst_n;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear();
    rq.delete();
    tq.delete();
    pq.delete();
    done_cnt = 0;
  endtask

  task automatic start_sweep(input logic [7:0] f, input logic [7:0] l);
    first = f;
    last  = l;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done_cnt == 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    tick();
    check(tag, 32'(done_cnt != 0), 32'd1);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!resp_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(resp_valid), 32'd1);
  endtask

  task automatic chk_reset(input string tag);
    check(tag, 32'({busy, done, terr, puf_en, puf_rst_n, resp_valid, resp_err,
                    puf_chall, resp_chall, resp_data}),
          32'({7'b0000100, 24'h0}));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int n;
    int bad;
    logic [7:0] c0, d0;

    repeat (3) tick();
    chk_reset("reset_state");
    rst = 1'b0;
    tick();
    clear();

    // basic sweep 01..03
    resp_ready = 1'b1;
    start_sweep(8'h01, 8'h03);
    n = 0;
    while (!resp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("t1_latency", 32'(n), 32'd6);
    wait_done("t1_done_seen");
    check("t1_count", 32'(rq.size()), 32'd3);
    check("t1_r0", rq[0], 32'h0000_01A4);
    check("t1_r1", rq[1], 32'h0000_02A7);
    check("t1_r2", rq[2], 32'h0000_03A6);
    check("t1_gap", 32'(tq[1] - tq[0]), 32'd7);
    check("t1_done_cnt", 32'(done_cnt), 32'd1);
    @(negedge clk);
    check("t1_busy_after", 32'({busy, puf_en}), 32'd0);

    // backpressure on the first response
    tick();
    clear();
    resp_ready = 1'b0;
    start_sweep(8'h01, 8'h03);
    wait_valid("t2_valid");
    c0 = resp_chall;
    d0 = resp_data;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (!resp_valid || resp_chall !== c0 || resp_data !== d0 || !puf_rst_n) bad++;
    end
    check("t2_stable", 32'(bad), 32'd0);
    check("t2_first", 32'({c0, d0}), 32'h0000_01A4);
    check("t2_pulses_held", 32'(pq.size()), 32'd1);
    tick();
    resp_ready = 1'b1;
    wait_done("t2_done_seen");
    check("t2_count", 32'(rq.size()), 32'd3);
    check("t2_r2", rq[2], 32'h0000_03A6);
    check("t2_pulses", 32'(pq.size()), 32'd3);

    // wrap-around and single challenge
    tick();
    clear();
    start_sweep(8'hFE, 8'h01);
    wait_done("t3_done_seen");
    check("t3_chall_seq", {pq[0], pq[1], pq[2], pq[3]}, 32'hFEFF_0001);
    check("t3_count", 32'(rq.size()), 32'd4);
    check("t3_r2", rq[2], 32'h0000_00A5);
    check("t3_done_cnt", 32'(done_cnt), 32'd1);
    tick();
    clear();
    start_sweep(8'h7F, 8'h7F);
    wait_done("t3_single_done");
    check("t3_single_count", 32'(rq.size()), 32'd1);
    check("t3_single_r0", rq[0], 32'h0000_7FDA);

    // timeout on challenge 02
    tick();
    clear();
    blk_chall = 8'h02;
    blk_en = 1'b1;
    start_sweep(8'h01, 8'h03);
    wait_done("t4_done_seen");
    blk_en = 1'b0;
    check("t4_count", 32'(rq.size()), 32'd3);
    check("t4_r1_err", rq[1], 32'h0001_0200);
    check("t4_r2", rq[2], 32'h0000_03A6);
    check("t4_timeout_gap", 32'(tq[1] - tq[0]), 32'd21);
    check("t4_after_gap", 32'(tq[2] - tq[1]), 32'd7);
    repeat (5) tick();
    check("t4_terr_kept", 32'(terr), 32'd1);

    // abort during WAIT of challenge 02
    clear();
    blk_en = 1'b1;
    start_sweep(8'h01, 8'h03);
    @(negedge clk);
    check("t5_terr_clr", 32'(terr), 32'd0);
    n = 0;
    while (!(puf_chall == 8'h02 && !puf_rst_n) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t5_reach_c2", 32'(n < 100), 32'd1);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    @(negedge clk);
    check("t5_abort_out", 32'({busy, puf_en, puf_rst_n, resp_valid}), 32'b0010);
    repeat (30) tick();
    check("t5_no_more_resp", 32'(rq.size()), 32'd1);
    check("t5_no_done", 32'(done_cnt), 32'd0);
    blk_en = 1'b0;
    clear();
    start_sweep(8'h05, 8'h05);
    wait_done("t5_restart_done");
    check("t5_restart_r0", rq[0], 32'h0000_05A0);
    check("t5_restart_terr", 32'(terr), 32'd0);

    // start during busy is ignored
    tick();
    clear();
    start_sweep(8'h10, 8'h11);
    repeat (2) tick();
    start_sweep(8'h30, 8'h30);
    wait_done("t6_done_seen");
    check("t6_count", 32'(rq.size()), 32'd2);
    check("t6_r0", rq[0], 32'h0000_10B5);
    check("t6_r1", rq[1], 32'h0000_11B4);

    // rst while holding a response
    tick();
    resp_ready = 1'b0;
    start_sweep(8'h40, 8'h41);
    wait_valid("t6_valid");
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_reset("t6_rst_out");
    tick();
    rst = 1'b0;
    repeat (5) tick();
    check("t6_idle", 32'({busy, resp_valid}), 32'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
